// File: rtl/btn_pkg.sv
// Shared state encodings, default timing and counter sizing for the push-button conditioner.
package btn_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PRESS   = 3'd1;
    localparam logic [2:0] SEND    = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam int DEF_DEBOUNCE_CYCLES = 1048576;
    localparam int DEF_REPEAT_DELAY    = 12500000;
    localparam int DEF_REPEAT_PERIOD   = 2500000;

    // One spare bit above the largest count keeps the terminal compare clear of wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchroniser, press/release debounce FSM and counter.
// Auto-repeat in HOLD is compiled in only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clock_25,
    input  logic reset,
    input  logic async_buttom,
    input  logic en_rise,
    output logic sync_buttom,
    output logic pressed
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             s_q, s_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic rep_q, rep_d;
`endif

    always_comb begin
        meta_d  = async_buttom;
        s_d     = meta_q;
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef BTN_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef BTN_AUTOREPEAT_EN
                rep_d = 1'b0;
`endif
                if (s_q) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!s_q)                  state_d = IDLE;
                else if (cnt_q == DEB_LAST) state_d = SEND;
                else                       cnt_d   = cnt_q + CNT_W'(1);
            end
            SEND: begin
                if (en_rise) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (!s_q) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!s_q) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                // First repeat waits the long delay, later ones the short period.
                else if (en_rise) begin
                    if (cnt_q == (rep_q ? PER_LAST : DLY_LAST)) begin
                        state_d = SEND;
                        rep_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
            RELEASE: begin
                if (s_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            s_q     <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rep_q   <= 1'b0;
`endif
        end else begin
            meta_q  <= meta_d;
            s_q     <= s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef BTN_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign sync_buttom = (state_q == SEND);
    assign pressed     = (state_q == SEND) || (state_q == HOLD) || (state_q == RELEASE);

endmodule

// File: rtl/button_debounce_array.sv
// N-channel push-button conditioner: one independent debounce channel per pin.
// Define BTN_AUTOREPEAT_EN to build in held-button auto-repeat.
module button_debounce_array
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic [N_BTN-1:0] async_buttom,
    input  logic [N_BTN-1:0] en_rise,
    output logic [N_BTN-1:0] sync_buttom,
    output logic [N_BTN-1:0] pressed,
    output logic             any_event
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clock_25     (clock_25),
            .reset        (reset),
            .async_buttom (async_buttom[i]),
            .en_rise      (en_rise[i]),
            .sync_buttom  (sync_buttom[i]),
            .pressed      (pressed[i])
        );
    end

    assign any_event = |sync_buttom;

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array; output pulses are checked against a cycle-stamped scoreboard.
module tb_button_debounce_array;

    logic       clock_25;
    logic       reset;
    logic [3:0] async_buttom;
    logic [3:0] en_rise;
    logic [3:0] sync_buttom;
    logic [3:0] pressed;
    logic       any_event;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   c0;

    button_debounce_array #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clock_25     (clock_25),
        .reset        (reset),
        .async_buttom (async_buttom),
        .en_rise      (en_rise),
        .sync_buttom  (sync_buttom),
        .pressed      (pressed),
        .any_event    (any_event)
    );

    initial begin
        clock_25 = 1'b0;
        forever #20 clock_25 = ~clock_25;
    end

    always @(posedge clock_25) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock_25);
    endtask

    // Every cycle with any output high must match the next scoreboard entry.
    always @(negedge clock_25) begin : mon
        exp_t e;
        if (sync_buttom !== 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {28'd0, sync_buttom}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_value", {28'd0, sync_buttom}, {28'd0, e.val});
            end
        end
    end

    initial begin
        reset        = 1'b1;
        async_buttom = 4'b0000;
        en_rise      = 4'b1111;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock_25);
        check("rst_sync", {28'd0, sync_buttom}, 32'd0);
        check("rst_pressed", {28'd0, pressed}, 32'd0);
        check("rst_any", {31'd0, any_event}, 32'd0);
        reset = 1'b1;
        @(negedge clock_25);

        // Clean pulse-mode press on channel 0, held 40 cycles.
        c0 = cyc;
        async_buttom = 4'b0001;
        push(c0 + 11, 4'b0001);
`ifdef BTN_AUTOREPEAT_EN
        push(c0 + 32, 4'b0001);
        push(c0 + 38, 4'b0001);
`endif
        wait_until(c0 + 10);
        check("s1_pressed_before", {28'd0, pressed}, 32'd0);
        wait_until(c0 + 11);
        check("s1_pressed_send", {28'd0, pressed}, 32'h1);
        check("s1_any_send", {31'd0, any_event}, 32'd1);
        wait_until(c0 + 12);
        check("s1_sync_after", {28'd0, sync_buttom}, 32'd0);
        wait_until(c0 + 40);
        async_buttom = 4'b0000;
        wait_until(c0 + 50);
        check("s1_pressed_release", {28'd0, pressed}, 32'h1);
        wait_until(c0 + 51);
        check("s1_pressed_idle", {28'd0, pressed}, 32'd0);
        check("s1_sb_empty", sb.size(), 32'd0);

        // Bouncy press on channel 1: 3H 2L 3H 2L produce nothing, then 10H gives one pulse.
        c0 = cyc;
        async_buttom = 4'b0010;
        wait_until(c0 + 3);  async_buttom = 4'b0000;
        wait_until(c0 + 5);  async_buttom = 4'b0010;
        wait_until(c0 + 8);  async_buttom = 4'b0000;
        wait_until(c0 + 10); async_buttom = 4'b0010;
        push(c0 + 21, 4'b0010);
        wait_until(c0 + 12);
        check("s2_bounce_pressed", {28'd0, pressed}, 32'd0);
        wait_until(c0 + 20);
        async_buttom = 4'b0000;
        wait_until(c0 + 40);
        check("s2_pressed_idle", {28'd0, pressed}, 32'd0);
        check("s2_sb_empty", sb.size(), 32'd0);

        // Level mode on channel 2 with a 4-cycle low glitch mid-hold.
        c0 = cyc;
        en_rise      = 4'b1011;
        async_buttom = 4'b0100;
        for (int k = 11; k <= 22; k++) push(c0 + k, 4'b0100);
        wait_until(c0 + 20); async_buttom = 4'b0000;
        wait_until(c0 + 24); async_buttom = 4'b0100;
        wait_until(c0 + 25);
        check("s3_pressed_glitch", {28'd0, pressed}, 32'h4);
        wait_until(c0 + 28);
        check("s3_no_reedge", {28'd0, sync_buttom}, 32'd0);
        check("s3_pressed_hold", {28'd0, pressed}, 32'h4);
        wait_until(c0 + 30); async_buttom = 4'b0000;
        wait_until(c0 + 40);
        check("s3_pressed_release", {28'd0, pressed}, 32'h4);
        wait_until(c0 + 41);
        check("s3_pressed_idle", {28'd0, pressed}, 32'd0);
        check("s3_sb_empty", sb.size(), 32'd0);
        en_rise = 4'b1111;

        // Channels 0 and 3 pressed together.
        c0 = cyc;
        async_buttom = 4'b1001;
        push(c0 + 11, 4'b1001);
        wait_until(c0 + 11);
        check("s4_any_high", {31'd0, any_event}, 32'd1);
        wait_until(c0 + 12);
        check("s4_any_low", {31'd0, any_event}, 32'd0);
        check("s4_pressed", {28'd0, pressed}, 32'h9);
        wait_until(c0 + 14); async_buttom = 4'b0000;
        wait_until(c0 + 26);
        check("s4_sb_empty", sb.size(), 32'd0);

        // Reset while ch0 is in HOLD and ch1 is mid-PRESS; both re-debounce from zero.
        c0 = cyc;
        async_buttom = 4'b0001;
        push(c0 + 11, 4'b0001);
        wait_until(c0 + 12); async_buttom = 4'b0011;
        wait_until(c0 + 18);
        check("s5_pressed_before_rst", {28'd0, pressed}, 32'h1);
        reset = 1'b0;
        #1;
        check("s5_rst_pressed", {28'd0, pressed}, 32'd0);
        check("s5_rst_sync", {28'd0, sync_buttom}, 32'd0);
        check("s5_rst_any", {31'd0, any_event}, 32'd0);
        wait_until(c0 + 21);
        reset = 1'b1;
        push(c0 + 32, 4'b0011);
        wait_until(c0 + 31);
        check("s5_pressed_restart", {28'd0, pressed}, 32'd0);
        wait_until(c0 + 32);
        check("s5_pressed_after", {28'd0, pressed}, 32'h3);
        wait_until(c0 + 35); async_buttom = 4'b0000;
        wait_until(c0 + 47);
        check("s5_pressed_idle", {28'd0, pressed}, 32'd0);
        check("s5_sb_empty", sb.size(), 32'd0);

        // Long hold on channel 3: auto-repeat when compiled in, otherwise one pulse.
        c0 = cyc;
        async_buttom = 4'b1000;
        push(c0 + 11, 4'b1000);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) push(c0 + 11 + 21 + 6 * k, 4'b1000);
`endif
        wait_until(c0 + 57); async_buttom = 4'b0000;
        wait_until(c0 + 67);
        check("s6_pressed_release", {28'd0, pressed}, 32'h8);
        wait_until(c0 + 68);
        check("s6_pressed_idle", {28'd0, pressed}, 32'd0);
        wait_until(c0 + 72);
        check("s6_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
